// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA line bursts and a host port; reads return 2 cycles after the slot decision.
// The host waits on host_ready, which is granted every HOST_EVERY-th burst slot or any idle cycle. Optional VGA_FB_ARB_STATS_EN adds wait/burst statistics.
module vga_fb_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 12,
   parameter int LEN_W      = 11,
   parameter int HOST_EVERY = 8
) (
   input  logic              MAX10_CLK1_50,
   input  logic              RESET,
   input  logic              disp_start,
   input  logic [ADDR_W-1:0] disp_addr,
   input  logic [LEN_W-1:0]  disp_len,
   output logic              disp_busy,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_done,
   output logic              disp_overrun,
   input  logic              host_valid,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ready,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_FB_ARB_STATS_EN
   ,
   output logic [15:0]       host_wait_cnt,
   output logic [LEN_W+2:0]  burst_max
`endif
);

   localparam int SLOT_W = $clog2(HOST_EVERY + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  remaining;
   logic [SLOT_W-1:0] slot_cnt;
   logic              tag_disp;
   logic              tag_last;
   logic              tag_host;
   logic              host_slot;
   logic              disp_issue;

   // slot_cnt runs 1..HOST_EVERY, so the host slot is simply the wrap point
   always_comb begin
      host_slot  = (state == BURST) && (slot_cnt == SLOT_W'(HOST_EVERY));
      host_ready = host_valid && ((state == IDLE) ? !disp_start : host_slot);
      disp_issue = (state == BURST) && !host_ready;
   end

   // RAM output is already registered; gate it so idle cycles read as zero
   assign disp_rdata = disp_rvalid ? mem_rdata : '0;
   assign host_rdata = host_rvalid ? mem_rdata : '0;

   always_ff @(posedge MAX10_CLK1_50) begin
      if (RESET) begin
         state        <= IDLE;
         cur_addr     <= '0;
         remaining    <= '0;
         slot_cnt     <= '0;
         tag_disp     <= 1'b0;
         tag_last     <= 1'b0;
         tag_host     <= 1'b0;
         disp_busy    <= 1'b0;
         disp_rvalid  <= 1'b0;
         disp_done    <= 1'b0;
         disp_overrun <= 1'b0;
         host_rvalid  <= 1'b0;
         mem_addr     <= '0;
         mem_we       <= 1'b0;
         mem_wdata    <= '0;
      end else begin
         tag_disp    <= 1'b0;
         tag_last    <= 1'b0;
         tag_host    <= 1'b0;
         mem_we      <= 1'b0;
         disp_rvalid <= tag_disp;
         disp_done   <= tag_disp && tag_last;
         host_rvalid <= tag_host;

         if (host_ready) begin
            mem_addr  <= host_addr;
            mem_we    <= host_we;
            mem_wdata <= host_wdata;
            tag_host  <= !host_we;
         end

         case (state)
            IDLE: begin
               if (disp_start && (disp_len != '0)) begin
                  cur_addr  <= disp_addr;
                  remaining <= disp_len;
                  slot_cnt  <= SLOT_W'(1);
                  disp_busy <= 1'b1;
                  state     <= BURST;
               end
            end
            BURST: begin
               if (disp_start)
                  disp_overrun <= 1'b1;
               slot_cnt <= host_slot ? SLOT_W'(1) : slot_cnt + SLOT_W'(1);
               if (disp_issue) begin
                  mem_addr  <= cur_addr;
                  tag_disp  <= 1'b1;
                  cur_addr  <= cur_addr + ADDR_W'(1);
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     tag_last  <= 1'b1;
                     disp_busy <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef VGA_FB_ARB_STATS_EN
   logic [LEN_W+2:0] burst_cyc;
   logic [LEN_W+2:0] burst_cyc_nxt;

   assign burst_cyc_nxt = burst_cyc + (LEN_W+3)'(1);

   always_ff @(posedge MAX10_CLK1_50) begin
      if (RESET) begin
         host_wait_cnt <= '0;
         burst_max     <= '0;
         burst_cyc     <= '0;
      end else begin
         if (host_valid && !host_ready && (host_wait_cnt != 16'hFFFF))
            host_wait_cnt <= host_wait_cnt + 16'd1;
         if (state == BURST) begin
            burst_cyc <= burst_cyc_nxt;
            if (burst_cyc_nxt > burst_max)
               burst_max <= burst_cyc_nxt;
         end else begin
            burst_cyc <= '0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: RAM model plus a display-data scoreboard filled at burst start.
module tb_vga_fb_arbiter;

   logic        MAX10_CLK1_50 = 1'b0;
   logic        RESET;
   logic        disp_start;
   logic [15:0] disp_addr;
   logic [10:0] disp_len;
   logic        disp_busy;
   logic        disp_rvalid;
   logic [11:0] disp_rdata;
   logic        disp_done;
   logic        disp_overrun;
   logic        host_valid;
   logic        host_we;
   logic [15:0] host_addr;
   logic [11:0] host_wdata;
   logic        host_ready;
   logic        host_rvalid;
   logic [11:0] host_rdata;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;
`ifdef VGA_FB_ARB_STATS_EN
   logic [15:0] host_wait_cnt;
   logic [13:0] burst_max;
`endif

   always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

   vga_fb_arbiter #(.ADDR_W(16), .DATA_W(12), .LEN_W(11), .HOST_EVERY(8)) dut (
      .MAX10_CLK1_50(MAX10_CLK1_50), .RESET(RESET),
      .disp_start(disp_start), .disp_addr(disp_addr), .disp_len(disp_len),
      .disp_busy(disp_busy), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .disp_done(disp_done), .disp_overrun(disp_overrun),
      .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
      .host_rdata(host_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef VGA_FB_ARB_STATS_EN
      , .host_wait_cnt(host_wait_cnt), .burst_max(burst_max)
`endif
   );

   // Storage holds value XOR background pattern so unwritten words read as a distinct pattern
   function automatic logic [11:0] bg(input logic [15:0] a);
      return a[11:0] ^ {a[15:12], 8'h5A};
   endfunction

   bit [11:0] ram    [65536];
   bit [11:0] shadow [65536];

   always @(posedge MAX10_CLK1_50) begin
      if (mem_we) ram[mem_addr] <= mem_wdata ^ bg(mem_addr);
      mem_rdata <= ram[mem_addr] ^ bg(mem_addr);
   end

   typedef struct packed {
      logic [11:0] data;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0, busy_total = 0, rv_total = 0, done_total = 0, hrv_total = 0;
   logic s_busy, s_rv, s_done, s_hr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mon();
      exp_t e;
      cyc++;
      s_busy = disp_busy;
      s_rv   = disp_rvalid;
      s_done = disp_done;
      s_hr   = host_ready;
      if (disp_busy === 1'b1)   busy_total++;
      if (disp_rvalid === 1'b1) rv_total++;
      if (disp_done === 1'b1)   done_total++;
      if (host_rvalid === 1'b1) hrv_total++;
      if (disp_rvalid === 1'b1 && RESET === 1'b0) begin
         chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("disp_rdata", 64'(disp_rdata), 64'(e.data));
            chk("disp_done", 64'(disp_done), 64'(e.last));
         end
      end
      if (disp_done === 1'b1) chk("done_with_rvalid", 64'(disp_rvalid), 64'(1));
   endtask

   task automatic step();
      @(negedge MAX10_CLK1_50);
      mon();
      @(posedge MAX10_CLK1_50);
      #1;
   endtask

   task automatic push_burst(input logic [15:0] a, input int n);
      logic [15:0] ai;
      for (int i = 0; i < n; i++) begin
         ai = a + 16'(i);
         sb.push_back({shadow[ai] ^ bg(ai), i == n - 1});
      end
   endtask

   task automatic wait_done(input int maxc, output int first_rv, output int done_cyc);
      bit found;
      found    = 1'b0;
      first_rv = -1;
      done_cyc = -1;
      for (int i = 0; i < maxc && !found; i++) begin
         step();
         if (s_rv && first_rv < 0) first_rv = cyc;
         if (s_done) begin
            found    = 1'b1;
            done_cyc = cyc;
         end
      end
      chk("done_timeout", 64'(found), 64'(1));
   endtask

   function automatic logic [63:0] out_vec();
      return {disp_busy, disp_rvalid, disp_done, disp_overrun, host_ready, host_rvalid,
              mem_we, mem_addr, mem_wdata, disp_rdata, host_rdata};
   endfunction

   initial begin
      int first_rv, done_cyc, bt0, rv0, dt0, hrv0, k, acc, bad, first_acc, hidx, ram_bad;

      RESET = 1'b1; disp_start = 1'b0; disp_addr = '0; disp_len = '0;
      host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      repeat (3) step();
      RESET = 1'b0;
      chk("reset_outputs", out_vec(), 64'd0);

      // reset in the middle of a burst
      disp_start = 1'b1; disp_addr = 16'h0200; disp_len = 11'd20;
      push_burst(16'h0200, 20);
      step();
      disp_start = 1'b0;
      repeat (7) step();
      RESET = 1'b1;
      repeat (3) step();
      RESET = 1'b0;
      sb.delete();
      chk("reset_mid_burst_outputs", out_vec(), 64'd0);
      rv0 = rv_total; dt0 = done_total;
      repeat (10) step();
      chk("rvalid_after_reset", 64'(rv_total - rv0), 64'd0);
      chk("done_after_reset", 64'(done_total - dt0), 64'd0);

      // host idle, 800-word burst
      bt0 = busy_total; rv0 = rv_total;
      disp_start = 1'b1; disp_addr = 16'h0100; disp_len = 11'd800;
      push_burst(16'h0100, 800);
      step();
      disp_start = 1'b0;
      chk("busy_t1", 64'(disp_busy), 64'd1);
      step();
      chk("mem_addr_t2", 64'(mem_addr), 64'h0100);
      chk("rvalid_t2", 64'(disp_rvalid), 64'd0);
      step();
      chk("rvalid_t3", 64'(disp_rvalid), 64'd1);
      wait_done(1000, first_rv, done_cyc);
      chk("burst800_span", 64'(done_cyc - first_rv + 1), 64'd800);
      chk("burst800_busy", 64'(busy_total - bt0), 64'd800);
      chk("burst800_rvalids", 64'(rv_total - rv0), 64'd800);
      step();

      // host writes held throughout a burst, tie with disp_start in the first cycle
      bt0 = busy_total; rv0 = rv_total;
      hidx = 0; acc = 0; bad = 0; first_acc = 0;
      disp_start = 1'b1; disp_addr = 16'h0500; disp_len = 11'd800;
      host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h8000; host_wdata = 12'd5;
      push_burst(16'h0500, 800);
      #1;
      chk("tie_host_ready", 64'(host_ready), 64'd0);
      k = 0;
      while (k < 3000) begin
         step();
         disp_start = 1'b0;
         if (k > 0 && s_busy && s_hr) begin
            acc++;
            if (k % 8 != 0) bad++;
            if (first_acc == 0) first_acc = k;
         end
         if (s_hr) begin
            shadow[host_addr] = host_wdata ^ bg(host_addr);
            hidx++;
            host_addr  = 16'h8000 + 16'(hidx);
            host_wdata = 12'(hidx * 37 + 5);
         end
         if (s_done) break;
         k++;
      end
      host_valid = 1'b0;
      chk("host_burst_timeout", 64'(k < 3000), 64'd1);
      chk("host_first_slot", 64'(first_acc), 64'd8);
      chk("host_offslot_accepts", 64'(bad), 64'd0);
      chk("host_accepts_in_burst", 64'(acc), 64'd114);
      chk("burst914_busy", 64'(busy_total - bt0), 64'd914);
      chk("burst914_rvalids", 64'(rv_total - rv0), 64'd800);
      repeat (3) step();
      ram_bad = 0;
      for (int i = 0; i < hidx; i++)
         if (ram[16'h8000 + 16'(i)] !== shadow[16'h8000 + 16'(i)]) ram_bad++;
      chk("ram_contents", 64'(ram_bad), 64'd0);

      // address wrap and overrun
      rv0 = rv_total; dt0 = done_total;
      disp_start = 1'b1; disp_addr = 16'hFFFE; disp_len = 11'd4;
      push_burst(16'hFFFE, 4);
      step();
      disp_start = 1'b0;
      chk("overrun_before", 64'(disp_overrun), 64'd0);
      step();
      chk("wrap_addr0", 64'(mem_addr), 64'hFFFE);
      disp_start = 1'b1; disp_addr = 16'h2000; disp_len = 11'd5;
      step();
      disp_start = 1'b0;
      chk("wrap_addr1", 64'(mem_addr), 64'hFFFF);
      chk("overrun_set", 64'(disp_overrun), 64'd1);
      step();
      chk("wrap_addr2", 64'(mem_addr), 64'h0000);
      step();
      chk("wrap_addr3", 64'(mem_addr), 64'h0001);
      wait_done(20, first_rv, done_cyc);
      repeat (4) step();
      chk("wrap_rvalids", 64'(rv_total - rv0), 64'd4);
      chk("wrap_dones", 64'(done_total - dt0), 64'd1);
      chk("overrun_sticky", 64'(disp_overrun), 64'd1);

      // host write then read in IDLE
      hrv0 = hrv_total;
      host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 12'hABC;
      #1;
      chk("idle_write_ready", 64'(host_ready), 64'd1);
      shadow[16'h0010] = 12'hABC ^ bg(16'h0010);
      step();
      host_valid = 1'b0;
      repeat (3) step();
      chk("write_no_rvalid", 64'(hrv_total - hrv0), 64'd0);
      host_valid = 1'b1; host_we = 1'b0;
      #1;
      chk("idle_read_ready", 64'(host_ready), 64'd1);
      step();
      host_valid = 1'b0;
      chk("host_rvalid_t1", 64'(host_rvalid), 64'd0);
      step();
      chk("host_rvalid_t2", 64'(host_rvalid), 64'd1);
      chk("host_rdata", 64'(host_rdata), 64'hABC);
      step();
      chk("host_rvalid_once", 64'(host_rvalid), 64'd0);

      // zero-length start is ignored
      bt0 = busy_total; dt0 = done_total;
      disp_start = 1'b1; disp_addr = 16'h0300; disp_len = 11'd0;
      step();
      disp_start = 1'b0;
      repeat (5) step();
      chk("len0_busy", 64'(busy_total - bt0), 64'd0);
      chk("len0_done", 64'(done_total - dt0), 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

- Shares one single-port synchronous framebuffer RAM between two requesters: the VGA scanout line-fetch engine and a host pixel reader/writer.
- Scanout requests a line burst once per line; the arbiter streams the burst at one read per cycle.
- Every HOST_EVERY-th burst slot is lent to a pending host access, and the host owns the port whenever no burst is active.
- Sits between the 800x600 timing generator (1040-cycle lines) and the framebuffer M9K array.

## Interface
Parameters:
- ADDR_W, 16, framebuffer word address width
- DATA_W, 12, pixel width (4R/4G/4B)
- LEN_W, 11, burst length width
- HOST_EVERY, 8, burst slot period reserved for host (≥2)

Ports:
- MAX10_CLK1_50  in  1  sole clock, all logic on rising edge
- RESET  in  1  synchronous, active-high
- disp_start  in  1  one-cycle pulse: begin line burst
- disp_addr  in  ADDR_W  burst start address, sampled with disp_start
- disp_len  in  LEN_W  burst length in words, sampled with disp_start
- disp_busy  out  1  burst in progress
- disp_rvalid  out  1  disp_rdata valid
- disp_rdata  out  DATA_W  burst read data, in address order
- disp_done  out  1  one-cycle pulse with last disp_rvalid of burst
- disp_overrun  out  1  sticky: disp_start arrived while busy
- host_valid  in  1  host request pending; held until host_ready
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ready  out  1  request accepted this cycle
- host_rvalid  out  1  host_rdata valid (reads only)
- host_rdata  out  DATA_W  host read data
- mem_addr  out  ADDR_W  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr

## Operation
- FSM states: IDLE, BURST.
- IDLE:
  - disp_start with disp_len≠0 latches addr/len, clears the slot counter to 1, and goes to BURST.
  - disp_len=0 is ignored: no busy, no done.
  - host_ready = host_valid && !disp_start; display wins a same-cycle tie.
- BURST: each cycle is a slot k = 1, 2, …
  - Host slot: k mod HOST_EVERY == 0 and host_valid. host_ready=1 and the host access is issued.
  - Otherwise the display issues a read at the current address, then increments the address (wraps mod 2^ADDR_W) and decrements the remaining count.
  - An unused host slot goes to the display. k advances every slot.
  - The slot that issues the last display read returns to IDLE; disp_busy deasserts the following cycle.
- disp_start while in BURST: ignored; disp_overrun set, cleared only by RESET.
- Host writes produce no rvalid. Host reads return exactly one host_rvalid.
- Reset values:
  - State IDLE.
  - disp_busy, disp_rvalid, disp_done, disp_overrun, host_ready, host_rvalid, mem_we = 0.
  - mem_addr, mem_wdata, disp_rdata, host_rdata = 0.
  - Slot counter and remaining count = 0.
- RESET mid-burst: burst aborted, in-flight read tags dropped, no rvalid/done after reset.

## Timing
- Slot decision at cycle t; mem_addr/mem_we/mem_wdata presented at t+1; disp_rvalid or host_rvalid at t+2, with rdata registered from mem_rdata.
- disp_start at cycle t gives the first mem_addr at t+2 and the first disp_rvalid at t+3.
- disp_busy asserts at t+1.
- Burst duration = L + floor((L−1)/(HOST_EVERY−1)) cycles worst case.
  - L=800, HOST_EVERY=8: at most 914 cycles, within the 1040-cycle line.
- With the host idle, burst duration = L cycles, back-to-back reads.
- Host latency: IDLE accept the same cycle as host_valid (if no disp_start); BURST accept at most HOST_EVERY−1 cycles after host_valid.
- host_ready is combinational from state, slot counter, host_valid, disp_start.
- The host must hold all host_* stable until host_ready.

## Configuration
- VGA_FB_ARB_STATS_EN defined:
  - Adds output host_wait_cnt [15:0], a saturating count of cycles with host_valid && !host_ready.
  - Adds output burst_max [LEN_W+2:0], the longest burst duration seen in cycles.
  - Both reset to 0 and are cleared by RESET only.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- RESET held 3 cycles during an active burst -> all outputs 0 the cycle after RESET; no disp_rvalid afterwards.
- Host idle, disp_start addr=0x0100 len=800 -> 800 consecutive disp_rvalid with data from addresses 0x0100..0x041F; disp_done on the 800th; burst 800 cycles.
- host_valid held (writes, incrementing addr) during len=800 burst, HOST_EVERY=8 -> host_ready at slots 8, 16, 24, …; burst 914 cycles; display data order intact; RAM contents match.
- disp_start and host_valid in the same IDLE cycle -> host_ready=0 that cycle; host accepted at slot 8.
- disp_start addr=0xFFFE len=4 -> reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001; a second disp_start mid-burst sets disp_overrun and leaves the data stream unchanged.
- Host read addr=0x0010 in IDLE -> host_rvalid 2 cycles after host_ready, host_rdata = previously written value; disp_len=0 start -> no busy, no done.
